pe_array_feeder: RTL and testbench
==================================

Name: pe_array_feeder

Overview:
Drives the activation side of pe_array. Accepts one row of matrix A per valid/ready beat and skews lane k by k cycles, so the array receives a correctly staggered wavefront. Drives compute for the whole stream plus a fixed zero-fed drain, then pulses done. Sits between the activation buffer/controller and pe_array.datas_in/compute; it replaces hand-staggering in benches.

Parameters:
ARRAY_SIZE, 2, lanes (array rows) and array dimension
COMPUTE_DATA_WIDTH, 4, signed activation width per lane
DRAIN_CYCLES, 2*ARRAY_SIZE, zero-fed compute cycles after the last row; must be >= 2*ARRAY_SIZE-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  row beat valid
in_ready  out  1  feeder can accept a row this cycle
in_row  in  ARRAY_SIZE*COMPUTE_DATA_WIDTH  signed lanes; lane k = bits [k*DW +: DW] = A[t][k]
in_last  in  1  marks the final row of the matrix
datas_out  out  ARRAY_SIZE x COMPUTE_DATA_WIDTH (unpacked, signed)  to pe_array.datas_in
compute  out  1  to pe_array.compute
busy  out  1  high in STREAM or DRAIN
done  out  1  one-cycle pulse after drain completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; datas_out all 0, compute=0, busy=0, done=0, in_ready=0 while asserted. All skew registers clear. Reset mid-stream aborts with no done pulse.
- Handshake: a beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and STREAM, 0 in DRAIN and DONE. in_row and in_last are sampled only on acceptance.
- Skew: lane k output is lane k of the accepted row delayed by k extra cycles. All outputs are registered.
  - Lane 0 of a beat accepted at edge n appears at datas_out[0] after edge n+1 (one-cycle latency).
  - Lane k appears after edge n+1+k.
- States:
  - IDLE: compute=0, datas_out=0. On accept go to STREAM, or straight to DRAIN if in_last=1.
  - STREAM: compute=1. Each cycle the skew line input is the accepted row, or all-zero (bubble) if no beat was accepted. Bubbles are legal and keep compute=1. An accept with in_last=1 goes to DRAIN.
  - DRAIN: compute=1, zeros enter the skew line. Counter runs 0..DRAIN_CYCLES-1, then go to DONE.
  - DONE: compute=0, done=1 for one cycle, datas_out forced to 0, then IDLE.
- compute is registered with datas_out, so the array sees the first row's lane 0 and compute=1 in the same cycle.
- Drain counter width is $clog2(DRAIN_CYCLES+1). No wrap: it saturates on reaching the terminal count.
- Values pass through unmodified; no arithmetic on data.

Optional Feature:
PE_ARRAY_FEEDER_ROWCNT_EN
- Defined: adds output rows_fed (16 bits). It clears on entering STREAM from IDLE, increments per accepted beat (saturating at 0xFFFF), and holds after done until the next stream.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- pe_array_pkg holds:
  - the feeder_state_t enum {IDLE, STREAM, DRAIN, DONE};
  - the default DRAIN_CYCLES helper function;
  - the activation lane typedef (signed [COMPUTE_DATA_WIDTH-1:0]).
- Sub-module skew_delay_line (params WIDTH, DEPTH, async active-low reset) is instantiated once per lane with DEPTH=k. DEPTH=0 is a wire.

Test Plan:
- Feed A=[[1,2],[3,4]] as two beats (second beat with in_last) on back-to-back cycles from IDLE:
  - datas_out after successive edges: [1,0], [3,2], [0,4], then [0,0];
  - compute=1 for 2+DRAIN_CYCLES=6 cycles, then done pulses once and compute=0.
- Bubble: beat [1,2], one idle cycle, then [3,4] with in_last:
  - datas_out sequence: [1,0], [0,2], [3,0], [0,4];
  - compute stays 1 throughout.
- Single beat [5,-3] with in_last from IDLE:
  - skips STREAM;
  - datas_out [5,0], [0,-3];
  - done after DRAIN_CYCLES cycles.
- Backpressure: in_valid held high during DRAIN/DONE:
  - in_ready=0, no beat accepted;
  - the next beat is accepted in the cycle after done, in IDLE.
- Reset asserted mid-STREAM after beat [7,7]:
  - datas_out, compute and busy go to 0 immediately without waiting for clk;
  - no done pulse;
  - after release, a fresh [1,2] stream behaves like the first scenario.
- With PE_ARRAY_FEEDER_ROWCNT_EN: a 3-row stream gives rows_fed=3 at done, and it resets to 1 on the next stream's first beat.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the PE array activation path.
package pe_array_pkg;

    localparam int unsigned PE_ARRAY_SIZE = 2;
    localparam int unsigned PE_DATA_WIDTH = 4;

    // One signed activation lane at the default data width.
    typedef logic signed [PE_DATA_WIDTH-1:0] act_lane_t;

    // Feeder control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    // Zero-fed cycles needed to flush the skew line and the array wavefront.
    function automatic int unsigned default_drain_cycles(input int unsigned array_size);
        return 2 * array_size;
    endfunction

endpackage

// File: rtl/pe_array_feeder_skew.sv
// skew_delay_line: fixed-depth register delay for one feeder lane.
// DEPTH = 0 degenerates to a plain wire.
module skew_delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign data_o = data_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Shift the lane value one stage per cycle.
        always_comb begin
            stage_d[0] = data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Stage registers, cleared by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/pe_array_feeder.sv
// pe_array_feeder: accepts rows of A, skews lane k by k cycles and drives
// pe_array.datas_in/compute, then a zero-fed drain and a done pulse.
// Optional PE_ARRAY_FEEDER_ROWCNT_EN adds the rows_fed beat counter output.
// The FSM works on the input side; every output is one register later, so
// compute/done/datas_out are time-aligned with each other at the array.
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE         = PE_ARRAY_SIZE,
    parameter int unsigned COMPUTE_DATA_WIDTH = PE_DATA_WIDTH,
    parameter int unsigned DRAIN_CYCLES       = default_drain_cycles(ARRAY_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] in_row,
    input  logic                                 in_last,
    output logic signed [COMPUTE_DATA_WIDTH-1:0] datas_out [ARRAY_SIZE],
    output logic                                 compute,
    output logic                                 busy,
`ifdef PE_ARRAY_FEEDER_ROWCNT_EN
    output logic [15:0]                          rows_fed,
`endif
    output logic                                 done
);

    localparam int unsigned DW    = COMPUTE_DATA_WIDTH;
    localparam int unsigned ROW_W = ARRAY_SIZE * DW;
    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES);

    feeder_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             feed_q, feed_d;
    logic             compute_q, compute_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;
    logic signed [DW-1:0] datas_out_q [ARRAY_SIZE];
    logic signed [DW-1:0] datas_out_d [ARRAY_SIZE];
    logic [DW-1:0]    lane_dly [ARRAY_SIZE];
    logic             accept_c;

    assign accept_c = in_valid && in_ready_q;

    // Next state, drain counter and skew-line input (row or bubble zeros).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = '0;
        feed_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    row_d   = in_row;
                    feed_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                feed_d = 1'b1;
                if (accept_c) begin
                    row_d = in_row;
                    if (in_last) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q != CNT_LAST) begin
                    feed_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE) || (state_d == STREAM);
        busy_d     = (state_d == STREAM) || (state_d == DRAIN);
        done_d     = (state_q == DONE);
        compute_d  = feed_q;
    end

    // FSM and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            feed_q     <= 1'b0;
            compute_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            feed_q     <= feed_d;
            compute_q  <= compute_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Lane k is delayed k extra cycles to form the wavefront.
    for (genvar k = 0; k < int'(ARRAY_SIZE); k++) begin : g_lane
        skew_delay_line #(
            .WIDTH (DW),
            .DEPTH (k)
        ) u_skew (
            .clk    (clk),
            .rst_n  (rst_n),
            .data_i (row_q[k*DW +: DW]),
            .data_o (lane_dly[k])
        );
    end

    // Output stage; the done cycle presents an all-zero row.
    always_comb begin
        for (int k = 0; k < int'(ARRAY_SIZE); k++) begin
            datas_out_d[k] = (state_q == DONE) ? '0 : $signed(lane_dly[k]);
        end
    end

    // Output data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(ARRAY_SIZE); k++) begin
                datas_out_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(ARRAY_SIZE); k++) begin
                datas_out_q[k] <= datas_out_d[k];
            end
        end
    end

`ifdef PE_ARRAY_FEEDER_ROWCNT_EN
    logic [15:0] rows_fed_q, rows_fed_d;

    // Beat counter: restarts at 1 on a stream's first beat, saturates, holds.
    always_comb begin
        rows_fed_d = rows_fed_q;
        if (accept_c) begin
            if (state_q == IDLE) begin
                rows_fed_d = 16'd1;
            end else if (rows_fed_q != 16'hFFFF) begin
                rows_fed_d = rows_fed_q + 16'd1;
            end
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_fed_q <= '0;
        end else begin
            rows_fed_q <= rows_fed_d;
        end
    end

    assign rows_fed = rows_fed_q;
`endif

    assign in_ready  = in_ready_q;
    assign compute   = compute_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign datas_out = datas_out_q;

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomized self-checking bench for pe_array_feeder against a cycle-indexed
// reference model (which row was accepted when, and where the stream ends).
module tb_pe_array_feeder;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 4;
    localparam int unsigned DC = 2 * N;
    localparam int unsigned RW = N * DW;
    localparam int          RING = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          in_last;
    logic signed [DW-1:0] datas_out [N];
    logic          compute;
    logic          busy;
    logic          done;
`ifdef PE_ARRAY_FEEDER_ROWCNT_EN
    logic [15:0]   rows_fed;
`endif

    pe_array_feeder #(
        .ARRAY_SIZE         (N),
        .COMPUTE_DATA_WIDTH (DW),
        .DRAIN_CYCLES       (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_last   (in_last),
        .datas_out (datas_out),
        .compute   (compute),
        .busy      (busy),
`ifdef PE_ARRAY_FEEDER_ROWCNT_EN
        .rows_fed  (rows_fed),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int            cyc;
    bit            m_ready;
    bit            started;
    bit            have_last;
    int            s_c;
    int            l_c;
    int            rows_m;
    logic [RW-1:0] ring [RING];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lane_of(input logic [RW-1:0] r, input int k);
        logic signed [DW-1:0] t;
        t = r[k*DW +: DW];
        return int'(t);
    endfunction

    function automatic logic [RW-1:0] mk(input int a0, input int a1);
        logic [RW-1:0] r;
        r[DW-1:0]    = DW'(a0);
        r[2*DW-1:DW] = DW'(a1);
        return r;
    endfunction

    task automatic reset_model();
        started   = 1'b0;
        have_last = 1'b0;
        m_ready   = 1'b0;
        rows_m    = 0;
        for (int i = 0; i < RING; i++) ring[i] = '0;
    endtask

    task automatic check_cycle();
        int exp_v;
        bit compute_e, busy_e, done_e;
        for (int k = 0; k < int'(N); k++) begin
            exp_v = lane_of(ring[(cyc - 1 - k) % RING], k);
            check_eq($sformatf("lane%0d@%0d", k, cyc), int'(datas_out[k]), exp_v);
        end
        compute_e = started && (cyc >= s_c + 1) && (!have_last || cyc <= l_c + int'(DC) + 1);
        busy_e    = started && (cyc >= s_c) && (!have_last || cyc <= l_c + int'(DC));
        done_e    = started && have_last && (cyc == l_c + int'(DC) + 2);
        check_eq($sformatf("compute@%0d", cyc), int'(compute), int'(compute_e));
        check_eq($sformatf("busy@%0d", cyc), int'(busy), int'(busy_e));
        check_eq($sformatf("done@%0d", cyc), int'(done), int'(done_e));
        check_eq($sformatf("in_ready@%0d", cyc), int'(in_ready), int'(m_ready));
`ifdef PE_ARRAY_FEEDER_ROWCNT_EN
        check_eq($sformatf("rows_fed@%0d", cyc), int'(rows_fed), rows_m);
`endif
    endtask

    // One clock: drive a beat, model the edge, check outputs 1 time unit later.
    task automatic step(input bit v, input logic [RW-1:0] row, input bit last);
        bit acc;
        in_valid = v;
        in_row   = row;
        in_last  = last;
        @(posedge clk);
        cyc++;
        acc = v && m_ready;
        if (acc) begin
            if (!started || have_last) begin
                started   = 1'b1;
                have_last = 1'b0;
                s_c       = cyc;
                rows_m    = 1;
            end else if (rows_m < 65535) begin
                rows_m++;
            end
            if (last) begin
                have_last = 1'b1;
                l_c       = cyc;
            end
        end
        ring[cyc % RING] = acc ? row : '0;
        m_ready = !(started && have_last && cyc >= l_c && cyc <= l_c + int'(DC) + 1);
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < int'(N); k++) begin
            check_eq($sformatf("%s_lane%0d", tag, k), int'(datas_out[k]), 0);
        end
        check_eq({tag, "_compute"}, int'(compute), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    // Asynchronous reset in the middle of a cycle, released on a falling edge.
    task automatic mid_reset(input string tag);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 32;
        s_c      = 0;
        l_c      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        in_last  = 1'b0;
        reset_model();
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Two back-to-back beats.
        step(1'b1, mk(1, 2), 1'b0);
        step(1'b1, mk(3, 4), 1'b1);
        idle(int'(DC) + 4);

        // Bubble inside a stream.
        step(1'b1, mk(1, 2), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, mk(3, 4), 1'b1);
        idle(int'(DC) + 4);

        // Single last beat straight from idle.
        step(1'b1, mk(5, -3), 1'b1);
        idle(int'(DC) + 4);

        // Valid held through drain/done: nothing taken until idle again.
        step(1'b1, mk(1, 1), 1'b1);
        repeat (int'(DC) + 4) step(1'b1, mk(6, -2), 1'b0);
        step(1'b1, mk(2, 3), 1'b1);
        idle(int'(DC) + 4);

        // Reset mid-stream, then a fresh stream.
        step(1'b1, mk(7, 7), 1'b0);
        mid_reset("mid");
        step(1'b1, mk(1, 2), 1'b0);
        step(1'b1, mk(3, 4), 1'b1);
        idle(int'(DC) + 4);

        // Three-row stream followed by a new stream.
        step(1'b1, mk(-8, 7), 1'b0);
        step(1'b1, mk(2, -1), 1'b0);
        step(1'b1, mk(4, 5), 1'b1);
        idle(int'(DC) + 4);
        step(1'b1, mk(3, 3), 1'b0);
        step(1'b1, mk(1, -4), 1'b1);
        idle(int'(DC) + 4);

        // Random traffic with bubbles, last markers and one reset.
        for (int i = 0; i < 400; i++) begin
            bit v, l;
            v = ($urandom_range(0, 99) < 60);
            l = ($urandom_range(0, 3) == 0);
            step(v, RW'($urandom), l);
            if (i == 200) mid_reset("rnd");
        end
        idle(int'(DC) + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
